// File: rtl/axi4_duth_noc_pkg.sv
// Shared NoC flit helpers plus the router input-unit state type.
// Flit layout: [1:0] type, then the output-port field above it.
package axi4_duth_noc_pkg;

   localparam int FLIT_FIELD_WIDTH = 2;
   localparam int OUTP_FIELD_MAX = 8;
   localparam int FLIT_LOW_W = FLIT_FIELD_WIDTH + OUTP_FIELD_MAX;

   typedef logic [FLIT_LOW_W-1:0] flit_low_t;

   typedef enum logic [FLIT_FIELD_WIDTH-1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_t;

   typedef enum logic {
      RIN_IDLE,
      RIN_ACTIVE
   } rtr_in_state_t;

   function automatic logic flit_is_head(flit_low_t f);
      return f[FLIT_FIELD_WIDTH-1:0] == FLIT_HEAD;
   endfunction

   function automatic logic flit_is_tail(flit_low_t f);
      return f[FLIT_FIELD_WIDTH-1:0] == FLIT_TAIL;
   endfunction

   function automatic logic flit_is_single(flit_low_t f);
      return f[FLIT_FIELD_WIDTH-1:0] == FLIT_SINGLE;
   endfunction

   // Outport field masked to pw bits.
   function automatic logic [OUTP_FIELD_MAX-1:0] flit_outport(
      flit_low_t f, int unsigned pw);
      logic [OUTP_FIELD_MAX-1:0] m;
      m = (OUTP_FIELD_MAX'(1) << pw) - OUTP_FIELD_MAX'(1);
      return f[FLIT_LOW_W-1:FLIT_FIELD_WIDTH] & m;
   endfunction

endpackage

// File: rtl/rtr_in_unit_if.sv
// Router input-unit bundle: upstream link, credits and switch allocation.
// master = upstream/allocator side, slave = the input unit.
interface rtr_in_unit_if #(
   parameter int OUT_PORTS  = 5,
   parameter int FLIT_WIDTH = 16
);
   logic [FLIT_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  credit_out;
   logic [OUT_PORTS-1:0]  outp_avail_in;
   logic [OUT_PORTS-1:0]  sa_reqs;
   logic [OUT_PORTS-1:0]  sa_grants;
   logic [FLIT_WIDTH-1:0] data_out;

   modport master (
      output data_in, valid_in, outp_avail_in, sa_grants,
      input  credit_out, sa_reqs, data_out
   );

   modport slave (
      input  data_in, valid_in, outp_avail_in, sa_grants,
      output credit_out, sa_reqs, data_out
   );
endinterface

// File: rtl/rtr_in_unit_fifo.sv
// Circular flit buffer for the router input unit.
// A push while full is dropped unless a pop frees the slot.
module rtr_in_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic wr_en, rd_en;

   function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign head  = mem_q[rd_ptr_q];
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = din;
      rd_ptr_d = rd_en ? nxt(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = wr_en ? nxt(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/rtr_in_unit.sv
// Router input unit: flit FIFO, outport decode, SA requests, credits.
// Define RTR_IN_BYPASS_EN for a zero-latency path when the FIFO is empty.
module rtr_in_unit
   import axi4_duth_noc_pkg::*;
#(
   parameter int OUT_PORTS  = 5,
   parameter int FLIT_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input logic         clk,
   input logic         rst,
   rtr_in_unit_if.slave bus
);
   localparam int unsigned PORT_W = $clog2(OUT_PORTS);

   rtr_in_state_t state_q, state_d;
   logic [OUT_PORTS-1:0] locked_q, locked_d;
   logic credit_q, credit_d;

   logic [FLIT_WIDTH-1:0] fifo_head, head_flit;
   logic fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic byp, have_head, pop;
   logic is_head, is_tail, is_single, port_ok;
   logic [OUTP_FIELD_MAX-1:0] outp;
   logic [OUT_PORTS-1:0] port_oh, reqs;
   flit_low_t hd;

`ifdef RTR_IN_BYPASS_EN
   assign byp = fifo_empty & bus.valid_in;
`else
   assign byp = 1'b0;
`endif

   assign head_flit = byp ? bus.data_in : fifo_head;
   assign have_head = ~fifo_empty | byp;
   assign hd        = FLIT_LOW_W'(head_flit);
   assign is_head   = flit_is_head(hd);
   assign is_tail   = flit_is_tail(hd);
   assign is_single = flit_is_single(hd);
   assign outp      = flit_outport(hd, PORT_W);
   assign port_ok   = outp < OUTP_FIELD_MAX'(OUT_PORTS);
   assign port_oh   = OUT_PORTS'(1) << outp;

   always_comb begin
      reqs     = '0;
      state_d  = state_q;
      locked_d = locked_q;
      unique case (state_q)
         RIN_IDLE:
            if (have_head && port_ok && (is_head || is_single))
               reqs = port_oh & bus.outp_avail_in;
         RIN_ACTIVE:
            if (have_head) reqs = locked_q;
      endcase
      pop = |(bus.sa_grants & reqs);
      if (pop) begin
         unique case (state_q)
            RIN_IDLE:
               if (is_head) begin
                  state_d  = RIN_ACTIVE;
                  locked_d = reqs;
               end
            RIN_ACTIVE:
               if (is_tail) state_d = RIN_IDLE;
         endcase
      end
      credit_d = pop;
   end

   // A bypassed flit granted in the same cycle never enters the FIFO.
   assign fifo_pop  = pop & ~byp;
   assign fifo_push = bus.valid_in & ~(byp & pop)
                    & (~fifo_full | fifo_pop);

   rtr_in_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(FLIT_WIDTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (fifo_push),
      .pop  (fifo_pop),
      .din  (bus.data_in),
      .head (fifo_head),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RIN_IDLE;
         locked_q <= '0;
         credit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         locked_q <= locked_d;
         credit_q <= credit_d;
      end
   end

   assign bus.sa_reqs    = reqs;
   assign bus.data_out   = head_flit;
   assign bus.credit_out = credit_q;
endmodule

// File: tb/tb_rtr_in_unit.sv
// Bench for rtr_in_unit: directed cases plus random traffic vs a queue model.
// Build with RTR_IN_BYPASS_EN to cover the bypass variant too.
module tb_rtr_in_unit;
   import axi4_duth_noc_pkg::*;

   localparam int OP = 5;
   localparam int FW = 16;
   localparam int DEPTH = 4;
`ifdef RTR_IN_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rtr_in_unit_if #(.OUT_PORTS(OP), .FLIT_WIDTH(FW)) bus ();

   rtr_in_unit #(
      .OUT_PORTS(OP), .FLIT_WIDTH(FW), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   int checks = 0;
   int failures = 0;

   logic [FW-1:0] q[$];
   bit in_pkt;
   int lport;
   bit exp_cred;
   int ucred;

   logic [OP-1:0] obs_req;
   logic obs_cred;
   logic [FW-1:0] obs_data;

   function automatic logic [FW-1:0] mk(int typ, int port, int pay);
      logic [31:0] t, p, y;
      t = typ; p = port; y = pay;
      return {y[10:0], p[2:0], t[1:0]};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Expected request from the buffered queue, packet state and inputs.
   function automatic logic [OP-1:0] m_req(
      logic v, logic [FW-1:0] d, logic [OP-1:0] av,
      output logic [FW-1:0] hd);
      logic [1:0] typ;
      int port;
      hd = '0;
      if (q.size() > 0) hd = q[0];
      else if (BYP && v) hd = d;
      else return '0;
      typ = hd[1:0];
      port = int'(hd[4:2]);
      if (in_pkt) return OP'(1) << lport;
      if ((typ == 2'd1 || typ == 2'd3) && port < OP)
         return (OP'(1) << port) & av;
      return '0;
   endfunction

   task automatic step(logic v, logic [FW-1:0] d,
                       logic [OP-1:0] av, logic [OP-1:0] g);
      logic [OP-1:0] er;
      logic [FW-1:0] hd;
      bit pop, consumed;
      bus.valid_in = v;
      bus.data_in = d;
      bus.outp_avail_in = av;
      bus.sa_grants = g;
      #3;
      er = m_req(v, d, av, hd);
      obs_req = bus.sa_reqs;
      obs_cred = bus.credit_out;
      obs_data = bus.data_out;
      chk("sa_reqs", 32'(obs_req), 32'(er));
      chk("credit_out", 32'(obs_cred), 32'(exp_cred));
      if (er != '0) chk("data_out", 32'(obs_data), 32'(hd));
      if (obs_cred) ucred++;
      if (v) ucred--;
      pop = |(g & er);
      consumed = 0;
      if (pop) begin
         if (!in_pkt && hd[1:0] == 2'd1) begin
            in_pkt = 1;
            lport = int'(hd[4:2]);
         end else if (in_pkt && hd[1:0] == 2'd2) begin
            in_pkt = 0;
         end
         if (q.size() > 0) void'(q.pop_front());
         else consumed = 1;
      end
      if (v && !consumed && q.size() < DEPTH) q.push_back(d);
      exp_cred = pop;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(logic [OP-1:0] av, logic [OP-1:0] g);
      step(1'b0, '0, av, g);
   endtask

   task automatic model_reset();
      q.delete();
      in_pkt = 0;
      lport = 0;
      exp_cred = 0;
      ucred = DEPTH;
   endtask

   initial begin
      logic [FW-1:0] d;
      logic [OP-1:0] av, g, er, hd_req;
      logic [FW-1:0] hd;
      logic v;
      bit g_pkt;
      int g_left;

      bus.valid_in = 1'b0;
      bus.data_in = '0;
      bus.outp_avail_in = '0;
      bus.sa_grants = '0;
      model_reset();
      rst = 1'b1;
      #2;
      chk("reset_reqs", 32'(bus.sa_reqs), 32'd0);
      chk("reset_credit", 32'(bus.credit_out), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single flit to port 2
      step(1'b1, mk(3, 2, 1), 5'b11111, 5'b00000);
      idle(5'b11111, 5'b00100);
      chk("t1_req", 32'(obs_req), 32'b00100);
      idle(5'b11111, 5'b00000);
      chk("t1_credit", 32'(obs_cred), 32'd1);
      chk("t1_empty", 32'(obs_req), 32'd0);

`ifdef RTR_IN_BYPASS_EN
      step(1'b1, mk(3, 0, 7), 5'b11111, 5'b00001);
      chk("t6_req", 32'(obs_req), 32'b00001);
      idle(5'b11111, 5'b00000);
      chk("t6_credit", 32'(obs_cred), 32'd1);
      chk("t6_empty", 32'(obs_req), 32'd0);
`endif

      // head/body/tail to port 1, availability drops after head
      step(1'b1, mk(1, 1, 2), 5'b11111, 5'b00000);
      step(1'b1, mk(0, 0, 3), 5'b11111, 5'b00010);
      chk("t2_head", 32'(obs_req), 32'b00010);
      step(1'b1, mk(2, 0, 4), 5'b11101, 5'b00010);
      chk("t2_body", 32'(obs_req), 32'b00010);
      idle(5'b11101, 5'b00010);
      chk("t2_tail", 32'(obs_req), 32'b00010);
      chk("t2_tail_data", 32'(obs_data), 32'(mk(2, 0, 4)));
      step(1'b1, mk(3, 1, 5), 5'b11101, 5'b00000);
      idle(5'b11101, 5'b00000);
      chk("t2_idle", 32'(obs_req), 32'd0);
      idle(5'b11111, 5'b00010);
      chk("t2_after", 32'(obs_req), 32'b00010);

      // head to port 3 held off by availability
      step(1'b1, mk(1, 3, 6), 5'b10111, 5'b00000);
      for (int i = 0; i < 5; i++) begin
         idle(5'b10111, 5'b01000);
         chk("t3_stall", 32'(obs_req), 32'd0);
         chk("t3_nocred", 32'(obs_cred), 32'd0);
      end
      idle(5'b11111, 5'b01000);
      chk("t3_req", 32'(obs_req), 32'b01000);
      step(1'b1, mk(2, 0, 7), 5'b00000, 5'b00000);
      chk("t3_credit", 32'(obs_cred), 32'd1);
      idle(5'b00000, 5'b01000);
      chk("t3_tail", 32'(obs_req), 32'b01000);
      idle(5'b11111, 5'b00000);

      // fill, then write+pop while full
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, mk(3, 0, k), 5'b11110, 5'b00000);
         chk("t4_fill", 32'(obs_req), 32'd0);
      end
      step(1'b1, mk(3, 0, 5), 5'b11111, 5'b00001);
      chk("t4_req", 32'(obs_req), 32'b00001);
      chk("t4_head", 32'(obs_data), 32'(mk(3, 0, 1)));
      for (int k = 2; k <= 5; k++) begin
         idle(5'b11111, 5'b00001);
         chk("t4_order", 32'(obs_data), 32'(mk(3, 0, k)));
         chk("t4_credit", 32'(obs_cred), 32'd1);
      end
      idle(5'b11111, 5'b00000);
      chk("t4_drained", 32'(obs_req), 32'd0);

      // reset mid-packet with three flits buffered
      step(1'b1, mk(1, 4, 8), 5'b11111, 5'b00000);
      step(1'b1, mk(0, 0, 9), 5'b11111, 5'b10000);
      step(1'b1, mk(0, 0, 10), 5'b11111, 5'b00000);
      step(1'b1, mk(0, 0, 11), 5'b11111, 5'b00000);
      step(1'b1, mk(0, 0, 12), 5'b11111, 5'b10000);
      chk("t5_pre_req", 32'(bus.sa_reqs), 32'b10000);
      chk("t5_pre_cred", 32'(bus.credit_out), 32'd1);
      bus.valid_in = 1'b0;
      bus.sa_grants = '0;
      rst = 1'b1;
      #1;
      chk("t5_rst_req", 32'(bus.sa_reqs), 32'd0);
      chk("t5_rst_cred", 32'(bus.credit_out), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(1'b1, mk(1, 2, 13), 5'b11111, 5'b00000);
      idle(5'b11111, 5'b00000);
      chk("t5_new_head", 32'(obs_req), 32'b00100);
      step(1'b1, mk(2, 0, 14), 5'b11111, 5'b00100);
      idle(5'b11111, 5'b00100);
      idle(5'b11111, 5'b00000);
      chk("t5_done", 32'(obs_req), 32'd0);

      // random traffic with credit-respecting upstream
      g_pkt = 0;
      g_left = 0;
      for (int n = 0; n < 3000; n++) begin
         v = 1'b0;
         d = '0;
         if (ucred > 0 && $urandom_range(3) != 0) begin
            v = 1'b1;
            if (!g_pkt) begin
               if ($urandom_range(2) == 0) begin
                  d = mk(3, int'($urandom_range(OP - 1)),
                         int'($urandom_range(2047)));
               end else begin
                  d = mk(1, int'($urandom_range(OP - 1)),
                         int'($urandom_range(2047)));
                  g_pkt = 1;
                  g_left = int'($urandom_range(3));
               end
            end else if (g_left > 0) begin
               d = mk(0, int'($urandom_range(7)),
                      int'($urandom_range(2047)));
               g_left--;
            end else begin
               d = mk(2, int'($urandom_range(7)),
                      int'($urandom_range(2047)));
               g_pkt = 0;
            end
         end
         for (int b = 0; b < OP; b++) av[b] = ($urandom_range(3) != 0);
         er = m_req(v, d, av, hd);
         hd_req = er;
         if (hd_req != '0 && $urandom_range(9) < 6) g = hd_req;
         else if ($urandom_range(2) == 0) g = '0;
         else g = OP'(1) << $urandom_range(OP - 1);
         step(v, d, av, g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
